mmio_seg_display: RTL and testbench

- Memory-mapped display peripheral on the CPU data-store path.
- Snoops store transactions and captures writes to a bank of N_CH 32-bit data registers plus one control register.
- Drives a time-multiplexed 7-segment display (one shared active-low segment bus plus active-low digit enables), showing the hex value of the selected channel.
- Adds readback, leading-zero blanking, channel select, enable, and a legacy alias address.

---
 rtl/mmio_seg_pkg.sv | 43 ++++
 rtl/mmio_seg_display_seg_scan_timer.sv | 34 +++
 rtl/mmio_seg_display.sv | 153 +++++++++++++++
 tb/tb_mmio_seg_display.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_seg_pkg.sv
// Shared constants, register-decode enum and hex-to-segment encoding for the
// memory-mapped 7-segment display peripheral.
package mmio_seg_pkg;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_BLZ     = 1;
    localparam int CTRL_SEL_LSB = 4;
    localparam int CTRL_SEL_MSB = 7;

    localparam logic [31:0] CTRL_RESET = 32'h0000_0001;
    localparam logic [6:0]  SEG_BLANK  = 7'h7F;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_DATA,
        REG_CTRL
    } reg_kind_e;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mmio_seg_display_seg_scan_timer.sv
// Digit-slot prescaler and digit index counter for the multiplexed display.
module seg_scan_timer
    import mmio_seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int N_DIGITS = 8,
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic [IW-1:0] idx
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc;
    logic          slot_end;

    assign slot_end = (presc == PW'(SCAN_DIV - 1));

    // The scan keeps running even while the display is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (slot_end) begin
            presc <= '0;
            idx   <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/mmio_seg_display.sv
// Store-snooping register bank with readback driving a time-multiplexed
// active-low 7-segment display of the selected channel's hex value.
module mmio_seg_display
    import mmio_seg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          N_CH       = 4,
    parameter logic [31:0] CTRL_OFFS  = 32'h40,
    parameter logic [31:0] ALIAS_ADDR = 32'h8000_0064,
    parameter int          N_DIGITS   = 8,
    parameter int          SCAN_DIV   = 50000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         mem_adr,
    input  logic [31:0]         mem_wdata,
    input  logic                wen,
    input  logic                ren,
    output logic [31:0]         rdata,
    output logic                rvalid,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] digit_n
);

    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [31:0] data_q [N_CH];
    logic        ctrl_en;
    logic        ctrl_blz;
    logic [3:0]  ctrl_sel;

    reg_kind_e   hit_kind;
    logic [CW-1:0] hit_ch;
    logic [31:0] ctrl_rd;
    logic [31:0] rd_val;

    logic [IW-1:0]         idx;
    logic [31:0]           sel_val;
    logic                  sel_ok;
    logic [N_DIGITS*4-1:0] shown;
    logic [N_DIGITS-1:0]   upper_zero;
    logic [3:0]            nib;
    logic [6:0]            seg_d;
    logic [N_DIGITS-1:0]   digit_n_d;

    seg_scan_timer #(
        .SCAN_DIV (SCAN_DIV),
        .N_DIGITS (N_DIGITS)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .idx (idx)
    );

    // Exact address match; the legacy alias lands on DATA0.
    always_comb begin
        hit_kind = REG_NONE;
        hit_ch   = '0;
        if (mem_adr == ALIAS_ADDR) begin
            hit_kind = REG_DATA;
            hit_ch   = '0;
        end
        if (mem_adr == BASE_ADDR + CTRL_OFFS) begin
            hit_kind = REG_CTRL;
        end
        for (int i = 0; i < N_CH; i++) begin
            if (mem_adr == BASE_ADDR + 32'(4 * i)) begin
                hit_kind = REG_DATA;
                hit_ch   = CW'(i);
            end
        end
    end

    always_comb begin
        ctrl_rd                             = '0;
        ctrl_rd[CTRL_EN]                    = ctrl_en;
        ctrl_rd[CTRL_BLZ]                   = ctrl_blz;
        ctrl_rd[CTRL_SEL_MSB:CTRL_SEL_LSB]  = ctrl_sel;
        case (hit_kind)
            REG_DATA: rd_val = data_q[hit_ch];
            REG_CTRL: rd_val = ctrl_rd;
            default:  rd_val = '0;
        endcase
    end

    // Register file and read port; reads see pre-write contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                data_q[i] <= '0;
            end
            ctrl_en  <= CTRL_RESET[CTRL_EN];
            ctrl_blz <= CTRL_RESET[CTRL_BLZ];
            ctrl_sel <= CTRL_RESET[CTRL_SEL_MSB:CTRL_SEL_LSB];
            rdata    <= '0;
            rvalid   <= 1'b0;
        end else begin
            if (wen) begin
                case (hit_kind)
                    REG_DATA: data_q[hit_ch] <= mem_wdata;
                    REG_CTRL: begin
                        ctrl_en  <= mem_wdata[CTRL_EN];
                        ctrl_blz <= mem_wdata[CTRL_BLZ];
                        ctrl_sel <= mem_wdata[CTRL_SEL_MSB:CTRL_SEL_LSB];
                    end
                    default: ;
                endcase
            end
            rvalid <= ren;
            if (ren) begin
                rdata <= rd_val;
            end
        end
    end

    // Pick the displayed nibble and decide leading-zero blanking.
    always_comb begin
        sel_ok  = (int'(ctrl_sel) < N_CH);
        sel_val = '0;
        if (sel_ok) begin
            sel_val = data_q[ctrl_sel[CW-1:0]];
        end
        shown = sel_val[N_DIGITS*4-1:0];
        nib   = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            upper_zero[i] = ((shown >> (4 * i)) == '0);
            if (idx == IW'(i)) begin
                nib = shown[4*i +: 4];
            end
        end

        digit_n_d = '1;
        seg_d     = SEG_BLANK;
        if (ctrl_en) begin
            digit_n_d = ~(N_DIGITS'(1) << idx);
            if (sel_ok && !(ctrl_blz && idx != '0 && upper_zero[idx])) begin
                seg_d = hex_to_seg(nib);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg     <= SEG_BLANK;
            digit_n <= '1;
        end else begin
            seg     <= seg_d;
            digit_n <= digit_n_d;
        end
    end

endmodule

// File: tb/tb_mmio_seg_display.sv
// Randomized self-checking bench for mmio_seg_display against a cycle-count
// based behavioural model of registers, scan position and display output.
module tb_mmio_seg_display;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] CTRL_A = 32'h8000_0040;
    localparam logic [31:0] ALIAS  = 32'h8000_0064;
    localparam int          NCH    = 4;
    localparam int          ND     = 8;
    localparam int          SD     = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        wen;
    logic        ren;
    logic [31:0] rdata;
    logic        rvalid;
    logic [6:0]  seg;
    logic [7:0]  digit_n;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] m_data [NCH];
    logic        m_en;
    logic        m_blz;
    logic [3:0]  m_sel;
    int          m_cyc;

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    mmio_seg_display #(
        .BASE_ADDR  (BASE),
        .N_CH       (NCH),
        .CTRL_OFFS  (32'h40),
        .ALIAS_ADDR (ALIAS),
        .N_DIGITS   (ND),
        .SCAN_DIV   (SD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_adr   (mem_adr),
        .mem_wdata (mem_wdata),
        .wen       (wen),
        .ren       (ren),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .seg       (seg),
        .digit_n   (digit_n)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < NCH; i++) begin
            if (a == BASE + 32'(4 * i)) v = m_data[i];
        end
        if (a == ALIAS) v = m_data[0];
        if (a == CTRL_A) v = {24'h0, m_sel, 2'b00, m_blz, m_en};
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) m_data[i] = 32'h0;
        m_en  = 1'b1;
        m_blz = 1'b0;
        m_sel = 4'h0;
        m_cyc = 0;
    endtask

    // Drive one cycle of inputs, advance the model and compare all outputs.
    task automatic applyStimulus(input logic r, input logic w, input logic rd,
                                 input logic [31:0] a, input logic [31:0] d);
        logic [6:0]  es;
        logic [7:0]  ed;
        logic [31:0] er;
        logic [31:0] val;
        logic [3:0]  nib;
        logic        ev;
        int          k;
        rst = r; wen = w; ren = rd; mem_adr = a; mem_wdata = d;
        k  = (m_cyc / SD) % ND;
        ed = 8'hFF;
        es = 7'h7F;
        if (m_en) begin
            ed = ~(8'd1 << k);
            if (int'(m_sel) < NCH) begin
                val = m_data[m_sel];
                nib = 4'((val >> (4 * k)) & 32'hF);
                if (!(m_blz && k > 0 && (val >> (4 * k)) == 32'h0)) es = hex_tab[nib];
            end
        end
        er = model_read(a);
        ev = rd;
        if (r) begin
            es = 7'h7F; ed = 8'hFF; er = 32'h0; ev = 1'b0;
            model_reset();
        end else begin
            if (w) begin
                for (int i = 0; i < NCH; i++) begin
                    if (a == BASE + 32'(4 * i)) m_data[i] = d;
                end
                if (a == ALIAS) m_data[0] = d;
                if (a == CTRL_A) begin
                    m_en = d[0]; m_blz = d[1]; m_sel = d[7:4];
                end
            end
            m_cyc++;
        end
        @(posedge clk);
        #1;
        checkOutput("digit_n", 32'(digit_n), 32'(ed));
        checkOutput("seg", 32'(seg), 32'(es));
        checkOutput("rvalid", 32'(rvalid), 32'(ev));
        if (ev || r) checkOutput("rdata", rdata, er);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(1'b0, 1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [31:0] a);
        applyStimulus(1'b0, 1'b0, 1'b1, a, 32'h0);
    endtask

    initial begin
        logic [31:0] a, d;
        logic        w, r, rs;
        int          pick;
        model_reset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        wr(BASE, 32'h1234_ABCD);
        idle(34);

        wr(ALIAS, 32'hDEAD_BEEF);
        rd(BASE);
        checkOutput("rd_alias", rdata, 32'hDEAD_BEEF);
        rd(BASE + 32'h100);
        checkOutput("rd_unmapped", rdata, 32'h0);
        checkOutput("rv_unmapped", 32'(rvalid), 32'h1);

        wr(CTRL_A, 32'h3);
        wr(BASE, 32'h0000_0050);
        idle(34);
        wr(BASE, 32'h0);
        idle(34);

        wr(BASE + 32'h8, 32'h7);
        wr(CTRL_A, 32'h21);
        idle(10);
        wr(CTRL_A, 32'hF1);
        idle(10);
        wr(CTRL_A, 32'h0);
        idle(10);
        rd(CTRL_A);
        checkOutput("ctrl_rd0", rdata, 32'h0);

        wr(BASE + 32'h4, 32'h5);
        applyStimulus(1'b0, 1'b1, 1'b1, BASE + 32'h4, 32'h9);
        checkOutput("rw_same_old", rdata, 32'h5);
        rd(BASE + 32'h4);
        checkOutput("rw_same_new", rdata, 32'h9);

        wr(CTRL_A, 32'hFFFF_FF31);
        rd(CTRL_A);
        checkOutput("ctrl_mask", rdata, 32'h31);
        wr(CTRL_A, 32'h1);
        for (int i = 0; i < 64 && ((m_cyc / SD) % ND) != 5; i++) idle(1);
        applyStimulus(1'b1, 1'b1, 1'b0, BASE, 32'hFFFF_FFFF);
        checkOutput("rst_seg", 32'(seg), 32'h7F);
        idle(1);
        checkOutput("post_rst_dig", 32'(digit_n), 32'hFE);
        checkOutput("post_rst_seg", 32'(seg), 32'h40);
        rd(CTRL_A);
        checkOutput("rst_ctrl", rdata, 32'h1);
        for (int i = 0; i < NCH; i++) begin
            rd(BASE + 32'(4 * i));
            checkOutput("rst_data", rdata, 32'h0);
        end

        for (int n = 0; n < 3000; n++) begin
            pick = int'($urandom_range(0, 9));
            case (pick)
                0, 1, 2, 3: a = BASE + 32'(4 * $urandom_range(0, NCH - 1));
                4, 5:       a = CTRL_A;
                6:          a = ALIAS;
                7:          a = BASE + 32'h44;
                8:          a = BASE + 32'h100;
                default:    a = $urandom;
            endcase
            if (a == CTRL_A) d = {$urandom_range(0, 15) == 0 ? 28'h0 : 28'(24'($urandom)),
                                  4'($urandom_range(0, 15) == 0 ? 0 : 1 + 2 * $urandom_range(0, 1))};
            else d = $urandom >> $urandom_range(0, 31);
            if (a == CTRL_A && $urandom_range(0, 3) != 0) d[7:6] = 2'b00;
            w  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 2) == 0) && (a != ALIAS);
            rs = ($urandom_range(0, 199) == 0);
            applyStimulus(rs, w, r, a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
